// File: rtl/pipe_scheduler.sv
// Pipe slot scheduler: once per accepted frame tick, scrolls every live pipe left one slot per
// cycle, retires pipes leaving the screen, optionally spawns one new pipe, and pulses score.
module pipe_scheduler #(
  parameter int          NUM_PIPES      = 3,
  parameter int          SCREEN_WIDTH   = 640,
  parameter int          PIPE_WIDTH     = 70,
  parameter int          SCROLL_SPEED   = 2,
  parameter int          SPAWN_INTERVAL = 120,
  parameter int          GAP_HEIGHT     = 120,
  parameter int          GAP_MIN_Y      = 180,
  parameter int          GAP_RANGE      = 200,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      clear,
  input  logic                      frame_tick,
  input  logic [9:0]                bird_x,
  output logic [32*NUM_PIPES-1:0]   pipe_x,
  output logic [32*NUM_PIPES-1:0]   pipe_ybot,
  output logic [32*NUM_PIPES-1:0]   pipe_gap,
  output logic                      score_pulse,
  output logic                      busy,
  output logic [2:0]                active_count
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_SPAWN  = 2'd2;

  localparam int              IDX_W    = (NUM_PIPES > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);
  localparam logic [31:0]     SPEED    = 32'(SCROLL_SPEED);
  localparam logic [31:0]     PW       = 32'(PIPE_WIDTH);
  localparam logic [31:0]     SPAWN_X  = 32'(SCREEN_WIDTH);
  localparam logic [31:0]     GAP_H    = 32'(GAP_HEIGHT);
  localparam logic [31:0]     MIN_Y    = 32'(GAP_MIN_Y);
  localparam logic [31:0]     LIMIT    = 32'(SPAWN_INTERVAL - 1);
  localparam logic [7:0]      RANGE8   = 8'(GAP_RANGE);

  // FSM state is kept as a plain named register so checkers can bind to it directly.
  logic [1:0]           state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [NUM_PIPES-1:0] valid, valid_n;
  logic [31:0]          x_q [NUM_PIPES];
  logic [31:0]          ybot_q [NUM_PIPES];
  logic [31:0]          gap_q [NUM_PIPES];
  logic [31:0]          x_n [NUM_PIPES];
  logic [31:0]          ybot_n [NUM_PIPES];
  logic [31:0]          gap_n [NUM_PIPES];
  logic [31:0]          spawn_cnt, cnt_n;
  logic [15:0]          lfsr;
  logic                 score_n;
  logic [2:0]           count_n;
  logic [31:0]          x_new;
  logic [31:0]          bird_ext;
  logic [7:0]           off;
  logic                 found;

  assign bird_ext = {22'd0, bird_x};

  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = valid;
    x_n     = x_q;
    ybot_n  = ybot_q;
    gap_n   = gap_q;
    cnt_n   = spawn_cnt;
    score_n = 1'b0;
    found   = 1'b0;
    x_new   = '0;
    off     = (lfsr[7:0] >= RANGE8) ? (lfsr[7:0] - RANGE8) : lfsr[7:0];
    case (state)
      ST_WAIT: begin
        if (frame_tick && run) begin
          state_n = ST_UPDATE;
          idx_n   = '0;
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (idx == IDX_W'(i) && valid[i]) begin
            if (x_q[i] < SPEED) begin
              valid_n[i] = 1'b0;
              x_n[i]     = '0;
              ybot_n[i]  = '0;
              gap_n[i]   = '0;
            end else begin
              x_new   = x_q[i] - SPEED;
              // Score on the step where the pipe's right edge crosses strictly left of the bird.
              score_n = (x_q[i] + PW >= bird_ext) && (x_new + PW < bird_ext);
              x_n[i]  = x_new;
            end
          end
        end
        if (idx == LAST_IDX) state_n = ST_SPAWN;
        else                 idx_n   = idx + 1'b1;
      end
      ST_SPAWN: begin
        state_n = ST_WAIT;
        if (spawn_cnt == LIMIT) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (!found && !valid[i]) begin
              found      = 1'b1;
              valid_n[i] = 1'b1;
              x_n[i]     = SPAWN_X;
              ybot_n[i]  = MIN_Y + {24'd0, off};
              gap_n[i]   = GAP_H;
            end
          end
          // With every slot taken the counter stays at its limit and the spawn retries next tick.
          if (found) cnt_n = '0;
        end else begin
          cnt_n = spawn_cnt + 32'd1;
        end
      end
      default: state_n = ST_WAIT;
    endcase
    if (clear) begin
      state_n = ST_WAIT;
      idx_n   = '0;
      valid_n = '0;
      cnt_n   = '0;
      score_n = 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_n[i]    = '0;
        ybot_n[i] = '0;
        gap_n[i]  = '0;
      end
    end
  end

  always_comb begin
    count_n = '0;
    for (int i = 0; i < NUM_PIPES; i++) count_n = count_n + 3'(valid_n[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_WAIT;
      idx          <= '0;
      valid        <= '0;
      spawn_cnt    <= '0;
      lfsr         <= LFSR_SEED;
      score_pulse  <= 1'b0;
      busy         <= 1'b0;
      active_count <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]    <= '0;
        ybot_q[i] <= '0;
        gap_q[i]  <= '0;
      end
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      valid        <= valid_n;
      spawn_cnt    <= cnt_n;
      lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      score_pulse  <= score_n;
      busy         <= (state_n != ST_WAIT);
      active_count <= count_n;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]    <= x_n[i];
        ybot_q[i] <= ybot_n[i];
        gap_q[i]  <= gap_n[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_out
    assign pipe_x[32*g+:32]    = x_q[g];
    assign pipe_ybot[32*g+:32] = ybot_q[g];
    assign pipe_gap[32*g+:32]  = gap_q[g];
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: tick-level reference model feeding an expected queue, plus
// directed checks for spawn, scoring, retirement, full slots, clear, run gating and reset.
module tb_pipe_scheduler;

  localparam int          NP   = 3;
  localparam int          SW   = 640;
  localparam int          PW   = 70;
  localparam int          SS   = 2;
  localparam int          SI   = 100;
  localparam int          GH   = 120;
  localparam int          GMIN = 180;
  localparam int          GR   = 200;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          W    = 3 * 32 * NP + 3 + 3 + 4;

  logic             clk = 1'b0;
  logic             reset, run, clear, frame_tick;
  logic [9:0]       bird_x;
  logic [32*NP-1:0] pipe_x, pipe_ybot, pipe_gap;
  logic             score_pulse, busy;
  logic [2:0]       active_count;

  pipe_scheduler #(
    .NUM_PIPES(NP), .SCREEN_WIDTH(SW), .PIPE_WIDTH(PW), .SCROLL_SPEED(SS),
    .SPAWN_INTERVAL(SI), .GAP_HEIGHT(GH), .GAP_MIN_Y(GMIN), .GAP_RANGE(GR), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .frame_tick(frame_tick),
    .bird_x(bird_x), .pipe_x(pipe_x), .pipe_ybot(pipe_ybot), .pipe_gap(pipe_gap),
    .score_pulse(score_pulse), .busy(busy), .active_count(active_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tick_no = 0;

  // ---------------- reference model ----------------
  logic        m_valid [NP];
  logic [31:0] m_x [NP];
  logic [31:0] m_ybot [NP];
  logic [31:0] m_gap [NP];
  int          m_cnt;
  logic [15:0] m_lfsr;
  logic [W-1:0] exp_q [$];
  logic [31:0] mid_x0;
  logic [2:0]  mid_active;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      m_valid[i] = 1'b0; m_x[i] = '0; m_ybot[i] = '0; m_gap[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic model_tick(input logic [15:0] l, output int sc);
    logic [31:0] xn;
    logic [7:0]  lb;
    int          fr;
    sc = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_valid[i]) begin
        if (m_x[i] < SS) begin
          m_valid[i] = 1'b0; m_x[i] = '0; m_ybot[i] = '0; m_gap[i] = '0;
        end else begin
          xn = m_x[i] - SS;
          if ((m_x[i] + PW >= {22'd0, bird_x}) && (xn + PW < {22'd0, bird_x})) sc++;
          m_x[i] = xn;
        end
      end
    end
    if (m_cnt == SI - 1) begin
      fr = -1;
      for (int i = 0; i < NP; i++) if (fr < 0 && !m_valid[i]) fr = i;
      if (fr >= 0) begin
        lb = l[7:0];
        m_valid[fr] = 1'b1;
        m_x[fr]     = SW;
        m_ybot[fr]  = GMIN + ((lb >= GR) ? (lb - GR) : lb);
        m_gap[fr]   = GH;
        m_cnt       = 0;
      end
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [W-1:0] pack_model(input int sc, input int bc);
    logic [32*NP-1:0] px, py, pg;
    int ac;
    ac = 0;
    for (int i = 0; i < NP; i++) begin
      px[32*i+:32] = m_x[i];
      py[32*i+:32] = m_ybot[i];
      pg[32*i+:32] = m_gap[i];
      ac += int'(m_valid[i]);
    end
    return {px, py, pg, 3'(ac), 3'(sc), 4'(bc)};
  endfunction

  // ---------------- drivers ----------------
  // Running tick: expected outcome is queued before the tick is driven, then compared once busy falls.
  task automatic do_tick(output int sc, output int bc);
    logic [15:0]  l;
    int           msc;
    logic         done;
    logic [W-1:0] exp_v, got_v;
    l = m_lfsr;
    for (int k = 0; k < NP + 1; k++) l = lfsr_step(l);
    model_tick(l, msc);
    exp_q.push_back(pack_model(msc, NP + 1));
    tick_no++;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    sc = 0; bc = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mid_x0     = pipe_x[31:0];
        mid_active = active_count;
      end
      if (score_pulse) sc++;
      if (busy) bc++;
      else done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL tick_timeout tick %0d: busy still 1 after 12 cycles, required 0", tick_no);
    end
    got_v = {pipe_x, pipe_ybot, pipe_gap, active_count, 3'(sc), 4'(bc)};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty tick %0d", tick_no);
    end else begin
      exp_v = exp_q.pop_front();
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL tick_state tick %0d: got %h required %h", tick_no, got_v, exp_v);
      end
    end
  endtask

  // Tick while run=0: nothing may move, so the expectation is the unchanged model state.
  task automatic idle_tick();
    int sc, bc;
    logic [W-1:0] exp_v, got_v;
    exp_q.push_back(pack_model(0, 0));
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    sc = 0; bc = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) bc++;
      if (score_pulse) sc++;
    end
    got_v = {pipe_x, pipe_ybot, pipe_gap, active_count, 3'(sc), 4'(bc)};
    exp_v = exp_q.pop_front();
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL idle_tick: got %h required %h", got_v, exp_v);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; run = 1'b0; clear = 1'b0; frame_tick = 1'b0; bird_x = 10'd170;
    repeat (3) @(negedge clk);
    model_clear();
    tests++;
    if ({pipe_x, pipe_ybot, pipe_gap} !== '0) begin
      fails++; $display("FAIL reset_fields: got %h required 0", {pipe_x, pipe_ybot, pipe_gap});
    end
    tests++;
    if ({score_pulse, busy, active_count} !== 5'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 00000", {score_pulse, busy, active_count});
    end
    reset = 1'b0;
    run   = 1'b1;
  endtask

  task automatic test_first_spawn();
    int sc, bc;
    logic [31:0] yb;
    repeat (SI - 1) do_tick(sc, bc);
    tests++;
    if ({pipe_x, active_count} !== '0) begin
      fails++; $display("FAIL pre_spawn_empty: got x=%h act=%0d required all 0", pipe_x, active_count);
    end
    do_tick(sc, bc);
    yb = pipe_ybot[31:0];
    tests++;
    if (pipe_x[31:0] !== 32'(SW) || pipe_gap[31:0] !== 32'(GH)) begin
      fails++; $display("FAIL spawn_slot0: got x=%0d gap=%0d required x=%0d gap=%0d",
                        pipe_x[31:0], pipe_gap[31:0], SW, GH);
    end
    tests++;
    if (!(yb >= 32'(GMIN) && yb < 32'(GMIN + GR))) begin
      fails++; $display("FAIL spawn_ybot_range: got %0d required [%0d,%0d)", yb, GMIN, GMIN + GR);
    end
    tests++;
    if (bc !== NP + 1) begin
      fails++; $display("FAIL busy_cycles: got %0d required %0d", bc, NP + 1);
    end
  endtask

  task automatic test_scroll_score();
    int sc, bc, guard;
    guard = 0;
    while (m_x[0] != 32'd100 && guard < 400) begin
      do_tick(sc, bc);
      guard++;
    end
    do_tick(sc, bc);
    tests++;
    if (sc !== 1 || pipe_x[31:0] !== 32'd98) begin
      fails++; $display("FAIL score_cross: got pulses=%0d x=%0d required pulses=1 x=98", sc, pipe_x[31:0]);
    end
    do_tick(sc, bc);
    tests++;
    if (sc !== 0) begin
      fails++; $display("FAIL score_once: got pulses=%0d required 0", sc);
    end
  endtask

  task automatic test_full_slots();
    int sc, bc, guard;
    logic spawned;
    guard = 0;
    while (m_cnt != SI - 1 && guard < 200) begin
      do_tick(sc, bc);
      guard++;
    end
    tests++;
    if (active_count !== 3'(NP)) begin
      fails++; $display("FAIL full_before: got active=%0d required %0d", active_count, NP);
    end
    do_tick(sc, bc);
    spawned = 1'b0;
    for (int i = 0; i < NP; i++) if (pipe_x[32*i+:32] == 32'(SW)) spawned = 1'b1;
    tests++;
    if (spawned !== 1'b0 || active_count !== 3'(NP)) begin
      fails++; $display("FAIL full_no_spawn: got spawned=%b active=%0d required 0/%0d", spawned, active_count, NP);
    end
    guard = 0;
    while (m_x[0] != 32'd0 && guard < 100) begin
      do_tick(sc, bc);
      guard++;
    end
  endtask

  task automatic test_retire();
    int sc, bc;
    do_tick(sc, bc);
    tests++;
    if (mid_x0 !== 32'd0 || mid_active !== 3'(NP - 1) || sc !== 0) begin
      fails++; $display("FAIL retire_slot0: got x=%0d active=%0d pulses=%0d required 0/%0d/0",
                        mid_x0, mid_active, sc, NP - 1);
    end
    tests++;
    if (pipe_x[31:0] !== 32'(SW) || active_count !== 3'(NP)) begin
      fails++; $display("FAIL held_spawn: got x=%0d active=%0d required %0d/%0d",
                        pipe_x[31:0], active_count, SW, NP);
    end
  endtask

  task automatic test_clear();
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL clear_pre_busy: got %b required 1", busy);
    end
    clear = 1'b1; frame_tick = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; frame_tick = 1'b0;
    model_clear();
    @(negedge clk);
    tests++;
    if ({pipe_x, pipe_ybot, pipe_gap, active_count, busy, score_pulse} !== '0) begin
      fails++; $display("FAIL clear_mid_update: got x=%h act=%0d busy=%b sp=%b required all 0",
                        pipe_x, active_count, busy, score_pulse);
    end
    clear = 1'b1; frame_tick = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL clear_beats_tick: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_run_low();
    int sc, bc;
    repeat (5) do_tick(sc, bc);
    run = 1'b0;
    repeat (10) idle_tick();
    run = 1'b1;
    repeat (SI - 6) do_tick(sc, bc);
    tests++;
    if (pipe_x !== '0) begin
      fails++; $display("FAIL run_low_counted: got x=%h required 0", pipe_x);
    end
    do_tick(sc, bc);
    tests++;
    if (pipe_x[31:0] !== 32'(SW)) begin
      fails++; $display("FAIL run_low_spawn: got x=%0d required %0d", pipe_x[31:0], SW);
    end
  endtask

  task automatic test_reset_mid_update();
    int sc, bc;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    tests++;
    if ({pipe_x, pipe_ybot, pipe_gap, active_count, busy, score_pulse} !== '0) begin
      fails++; $display("FAIL reset_mid_update: got x=%h act=%0d busy=%b required all 0",
                        pipe_x, active_count, busy);
    end
    repeat (SI) do_tick(sc, bc);
    tests++;
    if (pipe_x[31:0] !== 32'(SW) || active_count !== 3'd1) begin
      fails++; $display("FAIL respawn_after_reset: got x=%0d act=%0d required %0d/1",
                        pipe_x[31:0], active_count, SW);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_spawn();
    test_scroll_score();
    test_full_slots();
    test_retire();
    test_clear();
    test_run_low();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
